// File: rtl/tick_timer.sv
// tick_timer: prescaled tick counter with one-shot and periodic modes, abort,
// an early-warning flag (near) and a live elapsed-tick readout.
// Latency: start sampled at edge E0 -> count_done high in the cycle after E0 + count*TICK_DIV.
// Backpressure: none; start/stop are single-cycle strobes, every output is registered.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start, stop     1-cycle strobes: (re)arm / abort the timer (start has priority)
//   periodic, count mode and period in ticks, sampled only with start
//   busy            high while running
//   count_done      1-cycle pulse at each expiry (or right after start with count == 0)
//   near            high in the last NEAR_OFFSET ticks of a period
//   elapsed         ticks counted in the current period
// Legal parameters: TICK_DIV >= 1, 2**TICK_W >= TICK_DIV, NEAR_OFFSET <= 2**WIDE-1.
module tick_timer #(
  parameter int              WIDE        = 32,
  parameter int              TICK_DIV    = 50,
  parameter int              TICK_W      = 7,
  parameter longint unsigned NEAR_OFFSET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            periodic,
  input  logic [WIDE-1:0] count,
  output logic            busy,
  output logic            count_done,
  output logic            near,
  output logic [WIDE-1:0] elapsed
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [WIDE-1:0]   NEAR_W    = WIDE'(NEAR_OFFSET);

  logic [0:0]        state_q, state_d;
  logic [TICK_W-1:0] pre_q, pre_d;
  logic [WIDE-1:0]   count_to_q, count_to_d;
  logic [WIDE-1:0]   thr_q, thr_d;
  logic [WIDE-1:0]   elapsed_q, elapsed_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic              near_q, near_d;

  logic              tick;
  logic              expire;
  logic [WIDE-1:0]   thr_start;

  // Near threshold for a freshly latched period, saturating at 0 so that short
  // periods raise near from the first cycle instead of wrapping around.
  assign thr_start = (count > NEAR_W) ? (count - NEAR_W) : '0;

  assign tick   = (state_q == ST_RUN) && (pre_q == TICK_LAST);
  // Equality compare only: elapsed never exceeds count_to, so +1 cannot wrap.
  assign expire = tick && ((elapsed_q + WIDE'(1)) == count_to_q);

  always_comb begin
    state_d    = state_q;
    pre_d      = '0;
    count_to_d = count_to_q;
    thr_d      = thr_q;
    elapsed_d  = elapsed_q;
    mode_d     = mode_q;
    done_d     = 1'b0;

    if (start) begin
      count_to_d = count;
      mode_d     = periodic;
      thr_d      = thr_start;
      elapsed_d  = '0;
      if (count != '0) begin
        state_d = ST_RUN;
      end else begin
        // A zero period expires immediately and is never armed, even periodic.
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (stop && (state_q == ST_RUN)) begin
      // Abort: elapsed keeps its value, no expiry pulse.
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN) begin
      pre_d = tick ? '0 : (pre_q + TICK_W'(1));
      if (expire) begin
        done_d = 1'b1;
        if (mode_q) begin
          // Reload on the same edge; prescaler keeps running without a gap.
          elapsed_d = '0;
        end else begin
          elapsed_d = count_to_q;
          state_d   = ST_IDLE;
        end
      end else if (tick) begin
        elapsed_d = elapsed_q + WIDE'(1);
      end
    end

    // near tracks the values being registered this edge, so it lines up with
    // elapsed and drops together with busy on stop/expiry.
    near_d = (state_d == ST_RUN) && (elapsed_d >= thr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      count_to_q <= '0;
      thr_q      <= '0;
      elapsed_q  <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      near_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      count_to_q <= count_to_d;
      thr_q      <= thr_d;
      elapsed_q  <= elapsed_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      near_q     <= near_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign count_done = done_q;
  assign near       = near_q;
  assign elapsed    = elapsed_q;

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int NOFF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, stop, periodic;
  logic [W-1:0] count;
  logic         busy, count_done, near;
  logic [W-1:0] elapsed;

  logic         f_start;
  logic [W-1:0] f_count;
  logic         f_busy, f_done, f_near;
  logic [W-1:0] f_elapsed;

  tick_timer #(.WIDE(W), .TICK_DIV(D), .TICK_W(3), .NEAR_OFFSET(NOFF)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
    .count(count), .busy(busy), .count_done(count_done), .near(near),
    .elapsed(elapsed)
  );

  tick_timer #(.WIDE(W), .TICK_DIV(1), .TICK_W(1), .NEAR_OFFSET(NOFF)) dut_fast (
    .clk(clk), .rst(rst), .start(f_start), .stop(1'b0), .periodic(1'b0),
    .count(f_count), .busy(f_busy), .count_done(f_done), .near(f_near),
    .elapsed(f_elapsed)
  );

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_q[$];       // cycle numbers at which count_done must be seen
  bit mon_en = 1'b0;

  // Current run as issued by the stimulus: start edge, period, mode, stop offset.
  bit has_run = 1'b0;
  int r_t0, r_n, r_stopk;
  bit r_per;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: outputs k edges after the start edge, from tick arithmetic.
  function automatic void model(input int k, output bit eb, output bit en, output int ee);
    int kk, thr;
    bit stopped;
    thr = (r_n > NOFF) ? r_n - NOFF : 0;
    eb = 1'b0; en = 1'b0; ee = 0;
    if (r_n == 0) return;
    stopped = (r_stopk >= 0) && (k >= r_stopk);
    kk = stopped ? r_stopk - 1 : k;
    if (!r_per && (kk / D) >= r_n) begin
      ee = r_n;
      return;
    end
    ee = r_per ? (kk / D) % r_n : kk / D;
    if (!stopped) begin
      eb = 1'b1;
      en = (ee >= thr);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      bit eb, en;
      int ee, t;
      if (count_done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL done_extra: pulse at cycle %0d, none expected", cyc);
        end else begin
          t = exp_q.pop_front();
          if (t != cyc) begin
            bad++;
            $display("FAIL done_time: pulse at cycle %0d, expected cycle %0d", cyc, t);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        total++;
        bad++;
        $display("FAIL done_missing: no pulse at cycle %0d (now %0d)", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end

      if (!has_run || cyc >= r_t0) begin
        if (!has_run) begin
          eb = 1'b0; en = 1'b0; ee = 0;
        end else begin
          model(cyc - r_t0, eb, en, ee);
        end
        total++;
        if (busy !== eb || near !== en || elapsed !== W'(ee)) begin
          bad++;
          $display("FAIL state cyc=%0d: busy=%b near=%b elapsed=%0d, expected busy=%b near=%b elapsed=%0d",
                   cyc, busy, near, elapsed, eb, en, ee);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Expected pulses for a run whose next command is sampled L edges after start.
  task automatic push_done(input int t0, input int n, input bit per, input int L);
    if (n == 0) exp_q.push_back(t0);
    else if (!per) begin
      if (n * D < L) exp_q.push_back(t0 + n * D);
    end else begin
      for (int m = 1; m * n * D < L; m++) exp_q.push_back(t0 + m * n * D);
    end
  endtask

  task automatic do_start(input int n, input bit per, input int L, input bit with_stop);
    start = 1'b1; stop = with_stop; count = W'(n); periodic = per;
    has_run = 1'b1; r_t0 = cyc + 1; r_n = n; r_per = per; r_stopk = -1;
    push_done(cyc + 1, n, per, L);
    step();
    start = 1'b0; stop = 1'b0;
    count = W'($urandom); periodic = 1'($urandom);
    wait_cycles(L - 1);
  endtask

  task automatic do_stop(input int L);
    stop = 1'b1;
    if (has_run && r_stopk < 0) r_stopk = cyc + 1 - r_t0;
    step();
    stop = 1'b0;
    wait_cycles(L - 1);
  endtask

  initial begin
    int got, sel, n, L;
    bit per;
    rst = 1'b1; start = 1'b1; stop = 1'b0; periodic = 1'b0; count = W'(5);
    f_start = 1'b0; f_count = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    wait_cycles(5);

    do_start(5, 1'b0, 30, 1'b0);        // one-shot, near from elapsed 3
    do_start(3, 1'b1, 30, 1'b0);        // periodic, stopped at E0+30
    do_stop(10);
    do_start(0, 1'b0, 5, 1'b0);         // zero period, both modes
    do_start(0, 1'b1, 5, 1'b0);
    do_start(10, 1'b0, 17, 1'b0);       // re-armed at elapsed 4
    do_start(2, 1'b0, 20, 1'b0);
    do_start(6, 1'b0, 30, 1'b1);        // start and stop together
    do_start(1, 1'b0, 10, 1'b0);        // thr saturates at 0
    do_start(255, 1'b1, 1030, 1'b0);    // maximum period, one reload
    do_stop(5);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      L   = $urandom_range(1, 40);
      n   = $urandom_range(0, 7);
      per = 1'($urandom_range(0, 1));
      if (sel == 2) do_stop(L);
      else do_start(n, per, L, sel == 1);
    end
    do_stop(5);

    // TICK_DIV = 1 build: expiry count cycles after the start edge.
    f_count = W'(4); f_start = 1'b1;
    r_t0 = r_t0;
    got = cyc + 1;
    step();
    f_start = 1'b0;
    total++;
    if (f_busy !== 1'b1) begin
      bad++;
      $display("FAIL fast_busy: busy=%b, expected 1", f_busy);
    end
    n = got;
    got = -1;
    for (int i = 0; i < 20 && got < 0; i++) begin
      if (f_done === 1'b1) got = cyc;
      else step();
    end
    total++;
    if (got != n + 4) begin
      bad++;
      $display("FAIL fast_done: pulse at cycle %0d, expected cycle %0d", got, n + 4);
    end
    wait_cycles(3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL done_pending: %0d pulses never seen, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
